// File: rtl/cv_blinkcode_if.sv
// Heartbeat/status-code/LED signal bundle between system control and cv_blinkcode.
interface cv_blinkcode_if #(
    parameter int CODE_W = 4
);
    logic              hbin;
    logic [CODE_W-1:0] code;
    logic              led;
    logic              active;
    logic              seq_done;

    modport master (output hbin, output code, input led, input active, input seq_done);
    modport slave  (input hbin, input code, output led, output active, output seq_done);
endinterface

// File: rtl/cv_blinkcode.sv
// Turns heartbeat edges into ticks and flashes the LED N times per sequence for status code N;
// code 0 mirrors the heartbeat onto the LED.
module cv_blinkcode #(
    parameter int CODE_W    = 4,
    parameter int ON_TICKS  = 1,
    parameter int OFF_TICKS = 1,
    parameter int GAP_TICKS = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    cv_blinkcode_if.slave  bus
);
    localparam int MAX_A  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_T  = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
    localparam int TICK_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TICK_W-1:0] ON_RELOAD  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_RELOAD = TICK_W'(OFF_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_RELOAD = TICK_W'(GAP_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [CODE_W-1:0] BLINK_ONE  = CODE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              hbin_q, hbin_d;
    logic              led_q, led_d;
    logic              active_q, active_d;
    logic              seq_done_q, seq_done_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CODE_W-1:0] blink_cnt_q, blink_cnt_d;
    logic              tick_s;
    logic              launch_s;

    // Next-state logic: per-state tick handling, then the shared launch action.
    always_comb begin
        state_d     = state_q;
        hbin_d      = bus.hbin;
        led_d       = led_q;
        active_d    = active_q;
        seq_done_d  = 1'b0;
        tick_cnt_d  = tick_cnt_q;
        blink_cnt_d = blink_cnt_q;
        launch_s    = 1'b0;
        tick_s      = bus.hbin ^ hbin_q;

        case (state_q)
            ST_IDLE: begin
                led_d    = bus.hbin;
                launch_s = tick_s;
            end
            ST_ON: begin
                if (!tick_s) begin
                    tick_cnt_d = tick_cnt_q;
                end else if (tick_cnt_q == '0) begin
                    state_d    = ST_OFF;
                    led_d      = 1'b0;
                    tick_cnt_d = OFF_RELOAD;
                end else begin
                    tick_cnt_d = tick_cnt_q - TICK_ONE;
                end
            end
            ST_OFF: begin
                if (!tick_s) begin
                    tick_cnt_d = tick_cnt_q;
                end else if (tick_cnt_q != '0) begin
                    tick_cnt_d = tick_cnt_q - TICK_ONE;
                end else if (blink_cnt_q == BLINK_ONE) begin
                    state_d     = ST_GAP;
                    blink_cnt_d = '0;
                    tick_cnt_d  = GAP_RELOAD;
                end else begin
                    blink_cnt_d = blink_cnt_q - BLINK_ONE;
                    state_d     = ST_ON;
                    led_d       = 1'b1;
                    tick_cnt_d  = ON_RELOAD;
                end
            end
            ST_GAP: begin
                led_d = 1'b0;
                if (!tick_s) begin
                    tick_cnt_d = tick_cnt_q;
                end else if (tick_cnt_q != '0) begin
                    tick_cnt_d = tick_cnt_q - TICK_ONE;
                end else begin
                    seq_done_d = 1'b1;
                    launch_s   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Launch samples the code; a zero code drops straight back to mirroring.
        if (!launch_s) begin
            blink_cnt_d = blink_cnt_d;
        end else if (bus.code != '0) begin
            state_d     = ST_ON;
            led_d       = 1'b1;
            tick_cnt_d  = ON_RELOAD;
            blink_cnt_d = bus.code;
            active_d    = 1'b1;
        end else begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            led_d    = bus.hbin;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hbin_q      <= 1'b0;
            led_q       <= 1'b0;
            active_q    <= 1'b0;
            seq_done_q  <= 1'b0;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hbin_q      <= hbin_d;
            led_q       <= led_d;
            active_q    <= active_d;
            seq_done_q  <= seq_done_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.active   = active_q;
    assign bus.seq_done = seq_done_q;
endmodule
